// File: rtl/axi_burst_reader.sv
// AXI4 read initiator: turns (byte address, line count) into AR bursts and streams 512-bit lines out.
// Ports: command (cmd_*), line stream (out_*), status (done/err/busy), AXI AR/R master (*_m).
// Latency: AR one cycle after accept, data registered one cycle; done one cycle after last line drains.
// Backpressure: rready_m follows the single output register; one burst outstanding at a time.
module axi_burst_reader #(
    parameter int          MAX_BURST = 64,
    parameter logic [15:0] AXI_ID    = 16'h0
) (
    input  logic         clk,
    input  logic         rst,
    // command
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [63:0]  cmd_addr,
    input  logic [31:0]  cmd_lines,
    // line stream
    output logic [511:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    // status
    output logic         done,
    output logic         err,
    output logic         busy,
    // AXI read address channel
    output logic [15:0]  arid_m,
    output logic [63:0]  araddr_m,
    output logic [7:0]   arlen_m,
    output logic [2:0]   arsize_m,
    output logic         arvalid_m,
    input  logic         arready_m,
    // AXI read data channel
    input  logic [15:0]  rid_m,
    input  logic [511:0] rdata_m,
    input  logic [1:0]   rresp_m,
    input  logic         rlast_m,
    input  logic         rvalid_m,
    output logic         rready_m
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_FIN} state_t;

    localparam logic [31:0] LP_MAX = 32'(MAX_BURST);

    state_t         r_state;
    logic [63:0]    r_addr;
    logic [31:0]    r_rem;
    logic [8:0]     r_blen;
    logic [8:0]     r_cnt;
    logic           r_cmd_ready;
    logic           r_arvalid;
    logic           r_out_valid;
    logic [511:0]   r_out_data;
    logic           r_done;
    logic           r_err;
    logic           r_busy;

    logic [31:0]    w_pg;
    logic [31:0]    w_beats;
    logic           w_rready;
    logic           w_beat;
    logic           w_last;
    logic [31:0]    w_rem_next;
    logic [63:0]    w_addr_next;

    // Lines left before the next 4 KB page boundary (1..64).
    assign w_pg = 32'd64 - {26'd0, r_addr[11:6]};

    always_comb begin
        w_beats = r_rem;
        if (w_pg < w_beats) begin
            w_beats = w_pg;
        end
        if (LP_MAX < w_beats) begin
            w_beats = LP_MAX;
        end
    end

    assign w_rready    = !r_out_valid || out_ready;
    assign w_beat      = (r_state == S_DATA) && rvalid_m && w_rready;
    // Burst end is decided by our own beat count; rlast_m only feeds the error flag.
    assign w_last      = (r_cnt == (r_blen - 9'd1));
    assign w_rem_next  = r_rem - {23'd0, r_blen};
    assign w_addr_next = r_addr + {49'd0, r_blen, 6'd0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= 64'd0;
            r_rem       <= 32'd0;
            r_blen      <= 9'd0;
            r_cnt       <= 9'd0;
            r_cmd_ready <= 1'b1;
            r_arvalid   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 512'd0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // Output register: a new beat wins over a drain in the same cycle.
            if (w_beat) begin
                r_out_data  <= rdata_m;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        // Masking keeps the line-aligned address without leaving offset bits unused.
                        r_addr      <= cmd_addr & ~64'h3F;
                        r_rem       <= cmd_lines;
                        r_err       <= 1'b0;
                        r_busy      <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        if (cmd_lines != 32'd0) begin
                            r_state   <= S_ADDR;
                            r_arvalid <= 1'b1;
                        end else begin
                            r_state   <= S_FIN;
                        end
                    end
                end
                S_ADDR: begin
                    if (r_arvalid && arready_m) begin
                        r_arvalid <= 1'b0;
                        r_blen    <= w_beats[8:0];
                        r_cnt     <= 9'd0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt + 9'd1;
                        if ((rresp_m != 2'b00) || (rid_m != AXI_ID) || (rlast_m != w_last)) begin
                            r_err <= 1'b1;
                        end
                        if (w_last) begin
                            r_addr <= w_addr_next;
                            r_rem  <= w_rem_next;
                            if (w_rem_next != 32'd0) begin
                                r_state   <= S_ADDR;
                                r_arvalid <= 1'b1;
                            end else begin
                                r_state   <= S_FIN;
                            end
                        end
                    end
                end
                S_FIN: begin
                    // The done cycle stays inside FIN so busy is still high and cmd_ready low.
                    if (r_done) begin
                        r_done      <= 1'b0;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else if (!r_out_valid) begin
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign done      = r_done;
    assign err       = r_err;
    assign busy      = r_busy;
    assign arid_m    = AXI_ID;
    assign araddr_m  = r_addr;
    assign arlen_m   = 8'(w_beats - 32'd1);
    assign arsize_m  = 3'd6;
    assign arvalid_m = r_arvalid;
    assign rready_m  = w_rready;

endmodule
